mem_arbiter: RTL

- Shares one single-port unified memory between three requesters: instruction fetch (IF), data access (D) and a debug/loader port (DBG).
- Sits between the multi-cycle CPU core and memory, and sequences every access through a fixed request/ack handshake.
- Inserts a configurable number of memory wait states.
- Lets the bench or a loader write program images while the CPU is stalled waiting on its ack.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch,
// data and debug requesters, with configurable wait states.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t      state;
  state_t      state_n;
  logic [3:0]  wcnt;
  logic        last_dbg;
  logic [1:0]  grant;
  logic        sel_we;
  logic        last_cyc;

  // Pick the next grantee: D beats IF, DBG alternates with CPU.
  always_comb begin
    grant = 2'd0;
    if (dbg_req && (!(if_req || d_req) || !last_dbg))
      grant = 2'd3;
    else if (d_req)
      grant = 2'd2;
    else if (if_req)
      grant = 2'd1;
  end

  // Route the owner's address/data onto the memory bus.
  always_comb begin
    sel_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      unique case (owner)
        2'd1: mem_addr = if_addr;
        2'd2: begin
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          sel_we    = d_we;
        end
        2'd3: begin
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
          sel_we    = dbg_we;
        end
        default: ;
      endcase
    end
  end

  assign last_cyc = (state == ACCESS) && (wcnt == '0);
  assign mem_en   = (state == ACCESS);
  assign mem_we   = last_cyc && sel_we;
  assign busy     = (state != IDLE);
  assign if_ack   = (state == ACK) && (owner == 2'd1);
  assign d_ack    = (state == ACK) && (owner == 2'd2);
  assign dbg_ack  = (state == ACK) && (owner == 2'd3);

  // Next state: grant from IDLE, count waits, ack, back to IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (grant != 2'd0) state_n = ACCESS;
      ACCESS:  if (wcnt == '0) state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, wait counter, grant bookkeeping and read capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      last_dbg <= 1'b0;
      owner    <= 2'd0;
      rdata    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && grant != 2'd0) begin
        owner    <= grant;
        wcnt     <= WAIT_LD;
        last_dbg <= (grant == 2'd3);
      end
      if (state == ACCESS && wcnt != '0)
        wcnt <= wcnt - 4'd1;
      if (last_cyc && !sel_we)
        rdata <= mem_rdata;
    end
  end

endmodule
